// File: rtl/prison_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prison_pkg
// Brief    : Shared FSM state encoding and sizing constants for the prisoner
//            game load path.
// Revision : 1.0 - initial release
// ============================================================================
package prison_pkg;

  localparam int NUM_PRISONERS = 100;
  localparam int KEY_W         = 32;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    LOAD_BOXES     = 3'd1,
    LOAD_PRISONERS = 3'd2,
    RUN            = 3'd3,
    WAIT           = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/prison_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : prison_load_sequencer_if
// Brief    : Byte-stream input and game-side load bus of the load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface prison_load_sequencer_if;
  import prison_pkg::*;

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             load_boxes;
  logic             load_prisoners;
  logic [7:0]       select;
  logic [7:0]       data;
  logic [KEY_W-1:0] guard_key;
  logic             run;
  logic             game_done;
  logic             win;

  modport master (
    input  in_valid, in_data, game_done, win,
    output in_ready, load_boxes, load_prisoners, select, data, guard_key, run
  );

  modport slave (
    output in_valid, in_data, game_done, win,
    input  in_ready, load_boxes, load_prisoners, select, data, guard_key, run
  );

endinterface
`default_nettype wire

// File: rtl/perm_tracker.sv
`default_nettype none
// ============================================================================
// Module   : perm_tracker
// Brief    : N-bit seen bitmap; flags a byte legal if in range and unseen.
// Revision : 1.0 - initial release
// ============================================================================
module perm_tracker
  import prison_pkg::*;
#(
  parameter int N = NUM_PRISONERS
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       clr,
  input  wire logic       set,
  input  wire logic [7:0] idx,
  output logic            legal
);

  localparam int c_IW = $clog2(N);

  logic [N-1:0]    r_seen;
  logic [c_IW-1:0] w_bit;
  logic            w_in_range;

  assign w_bit      = idx[c_IW-1:0];
  assign w_in_range = ({24'd0, idx} < 32'(N));
  // The bitmap read is only meaningful when in range; the AND masks the rest.
  assign legal      = w_in_range && !r_seen[w_bit];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen <= '0;
    end else if (clr) begin
      r_seen <= '0;
    end else if (set) begin
      r_seen[w_bit] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prison_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prison_load_sequencer
// Brief    : Loads box contents from a byte stream, auto-loads prisoners,
//            starts the game and captures its result or a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module prison_load_sequencer
  import prison_pkg::*;
#(
  parameter int N       = NUM_PRISONERS,
  parameter int TIMEOUT = 1024
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [KEY_W-1:0] key_in,
  prison_load_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  result_win,
  output logic                  perm_error,
  output logic                  timeout
);

  localparam int              c_CW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      c_LAST_IDX  = 8'(N - 1);
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_idx;
  logic [c_CW-1:0] r_wait_cnt;
  logic            w_accept;
  logic            w_legal;
  logic            w_clr;
  logic            w_set;

  assign w_accept = (r_state == LOAD_BOXES) && bus.in_ready && bus.in_valid;
  assign w_clr    = (r_state == IDLE) && start;
  assign w_set    = w_accept && w_legal;

  perm_tracker #(
    .N (N)
  ) u_perm_tracker (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .set   (w_set),
    .idx   (bus.in_data),
    .legal (w_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= IDLE;
      r_idx              <= '0;
      r_wait_cnt         <= '0;
      bus.in_ready       <= 1'b0;
      bus.load_boxes     <= 1'b0;
      bus.load_prisoners <= 1'b0;
      bus.select         <= '0;
      bus.data           <= '0;
      bus.guard_key      <= '0;
      bus.run            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      result_win         <= 1'b0;
      perm_error         <= 1'b0;
      timeout            <= 1'b0;
    end else begin
      bus.load_boxes     <= 1'b0;
      bus.load_prisoners <= 1'b0;
      bus.run            <= 1'b0;
      done               <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            bus.guard_key <= key_in;
            r_idx         <= '0;
            result_win    <= 1'b0;
            perm_error    <= 1'b0;
            timeout       <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b1;
            r_state       <= LOAD_BOXES;
          end
        end

        LOAD_BOXES: begin
          if (w_accept) begin
            if (w_legal) begin
              bus.load_boxes <= 1'b1;
              bus.select     <= r_idx;
              bus.data       <= bus.in_data;
              if (r_idx == c_LAST_IDX) begin
                r_idx        <= '0;
                bus.in_ready <= 1'b0;
                r_state      <= LOAD_PRISONERS;
              end else begin
                r_idx <= r_idx + 8'd1;
              end
            end else begin
              // Out-of-range or duplicate content: abort without a strobe.
              perm_error   <= 1'b1;
              done         <= 1'b1;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end

        LOAD_PRISONERS: begin
          bus.load_prisoners <= 1'b1;
          bus.select         <= r_idx;
          bus.data           <= r_idx;
          if (r_idx == c_LAST_IDX) begin
            r_idx   <= '0;
            r_state <= RUN;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end

        RUN: begin
          bus.run    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end

        WAIT: begin
          if (bus.game_done) begin
            result_win <= bus.win;
            done       <= 1'b1;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            timeout    <= 1'b1;
            result_win <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prison_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prison_load_sequencer
// Brief    : Directed self-checking bench for prison_load_sequencer (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prison_load_sequencer;
  import prison_pkg::*;

  localparam int c_N  = 4;
  localparam int c_TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] key_in;
  logic        busy, done, result_win, perm_error, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] b_main [4] = '{8'd2, 8'd0, 8'd3, 8'd1};
  logic [7:0] b_irr  [4] = '{8'd3, 8'd1, 8'd0, 8'd2};
  int         g_irr  [4] = '{2, 0, 3, 1};
  logic [7:0] b_rst  [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
  logic [7:0] b_post [4] = '{8'd1, 8'd3, 8'd0, 8'd2};

  prison_load_sequencer_if bus ();

  prison_load_sequencer #(
    .N       (c_N),
    .TIMEOUT (c_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .result_win (result_win),
    .perm_error (perm_error),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  logic [18:0] w_strb;
  logic [56:0] w_all;
  assign w_strb = {bus.load_boxes, bus.load_prisoners, bus.run, bus.select, bus.data};
  assign w_all  = {bus.in_ready, bus.load_boxes, bus.load_prisoners, bus.select, bus.data,
                   bus.guard_key, bus.run, busy, done, result_win, perm_error, timeout};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strb(input string tag, input logic lb, input logic lp, input logic rn,
                          input logic [7:0] sel, input logic [7:0] dat);
    chk(tag, 64'(w_strb), 64'({lb, lp, rn, sel, dat}));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [31:0] key);
    start  = 1'b1;
    key_in = key;
    step();
    start  = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    key_in        = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.game_done = 1'b0;
    bus.win       = 1'b0;
    #2 rst = 1'b1;
    #3;
    chk("reset_all_zero", 64'(w_all), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_after_reset", 64'(w_all), 64'd0);

    // Full game: back-to-back box bytes, prisoner auto-load, run, win.
    start_game(32'hDEADBEEF);
    chk("start_ready_busy", 64'({bus.in_ready, busy}), 64'(2'b11));
    chk("guard_key", 64'(bus.guard_key), 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      feed(b_main[i]);
      chk_strb("load_boxes", 1'b1, 1'b0, 1'b0, 8'(i), b_main[i]);
    end
    chk("ready_drops", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_strb("load_prisoners", 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
    end
    step();
    chk_strb("run_pulse", 1'b0, 1'b0, 1'b1, 8'd3, 8'd3);
    step();
    chk_strb("run_single", 1'b0, 1'b0, 1'b0, 8'd3, 8'd3);
    step();
    step();
    bus.game_done = 1'b1;
    bus.win       = 1'b1;
    step();
    bus.game_done = 1'b0;
    bus.win       = 1'b0;
    chk("win_done", 64'({done, result_win, busy, timeout}), 64'(4'b1100));
    step();
    chk("win_held", 64'({done, result_win, busy}), 64'(3'b010));

    // Duplicate byte: one strobe, then abort.
    start_game(32'h1);
    chk("start_clears_win", 64'(result_win), 64'd0);
    feed(8'd1);
    chk_strb("dup_first", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
    feed(8'd1);
    chk_strb("dup_no_strobe", 1'b0, 1'b0, 1'b0, 8'd0, 8'd1);
    chk("dup_abort", 64'({perm_error, done, busy, bus.in_ready}), 64'(4'b1100));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dup_quiet", 64'({bus.load_boxes, bus.load_prisoners, bus.run, done}), 64'd0);
    end
    chk("dup_err_held", 64'(perm_error), 64'd1);

    // Out-of-range byte.
    start_game(32'h2);
    chk("start_clears_err", 64'(perm_error), 64'd0);
    feed(8'd4);
    chk("range_no_strobe", 64'({bus.load_boxes, bus.load_prisoners}), 64'd0);
    chk("range_abort", 64'({perm_error, done, busy}), 64'(3'b110));

    // Irregular in_valid, then let the game time out.
    start_game(32'h3);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < g_irr[i]; g++) begin
        step();
        chk("gap_quiet", 64'({bus.load_boxes, bus.in_ready}), 64'(2'b01));
      end
      feed(b_irr[i]);
      chk_strb("irr_load_boxes", 1'b1, 1'b0, 1'b0, 8'(i), b_irr[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_strb("irr_load_prisoners", 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
    end
    step();
    chk("irr_run", 64'(bus.run), 64'd1);
    for (int k = 1; k < c_TO; k++) begin
      step();
      chk("wait_no_done", 64'({done, timeout, busy}), 64'(3'b001));
    end
    step();
    chk("timeout_done", 64'({done, timeout, result_win, busy}), 64'(4'b1100));

    // Reset during prisoner loading, then a clean game.
    start_game(32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      feed(b_rst[i]);
    end
    step();
    step();
    step();
    chk_strb("pre_reset_lp2", 1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 64'(w_all), 64'd0);
    step();
    step();
    chk("reset_held", 64'(w_all), 64'd0);
    rst = 1'b0;
    step();
    start_game(32'hCAFE_0001);
    chk("post_key", 64'(bus.guard_key), 64'h0000_0000_CAFE_0001);
    for (int i = 0; i < 4; i++) begin
      feed(b_post[i]);
      chk_strb("post_load_boxes", 1'b1, 1'b0, 1'b0, 8'(i), b_post[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_strb("post_load_prisoners", 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
    end
    step();
    chk("post_run", 64'(bus.run), 64'd1);
    bus.game_done = 1'b1;
    bus.win       = 1'b0;
    step();
    bus.game_done = 1'b0;
    chk("post_lose_done", 64'({done, result_win, timeout, perm_error, busy}), 64'(5'b10000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
